// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared helpers for the data_mux slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Select width for an n-way mux; a 1-bit select is the minimum.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : mux_pkg
`default_nettype wire

// File: rtl/data_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mux_if
//  Description : Data/select/result bundle between a data_mux and its user.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mux_if
    import mux_pkg::*;
#(
    parameter int NUM_INPUTS = 6,
    parameter int DATA_WIDTH = 8
);
    localparam int SEL_WIDTH = sel_width(NUM_INPUTS);

    logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data_bus;
    logic [SEL_WIDTH-1:0]             i_select;
    logic [DATA_WIDTH-1:0]            o_output;
    logic                             o_sel_err;
    logic [DATA_WIDTH-1:0]            o_output_q;
    logic                             o_sel_err_q;

    modport master (
        output i_data_bus,
        output i_select,
        input  o_output,
        input  o_sel_err,
        input  o_output_q,
        input  o_sel_err_q
    );

    modport slave (
        input  i_data_bus,
        input  i_select,
        output o_output,
        output o_sel_err,
        output o_output_q,
        output o_sel_err_q
    );

endinterface : data_mux_if
`default_nettype wire

// File: rtl/mux_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_out_reg
//  Description : Async-reset register stage for the mux result and error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_out_reg #(
    parameter int WIDTH = 9
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q <= '0;
        end else begin
            data_q <= i_d;
        end
    end

    assign o_q = data_q;

endmodule : mux_out_reg
`default_nettype wire

// File: rtl/data_mux.sv
`default_nettype none
// ============================================================================
//  Module      : data_mux
//  Description : N:1 word selector with combinational and registered outputs
//                plus an out-of-range select flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mux
    import mux_pkg::*;
#(
    parameter int NUM_INPUTS = 6,
    parameter int DATA_WIDTH = 8
) (
    input  wire logic i_clk,
    input  wire logic i_rst,
    data_mux_if.slave bus
);

    localparam int SEL_WIDTH = sel_width(NUM_INPUTS);

    if (NUM_INPUTS < 2 || DATA_WIDTH < 1) begin : g_param_check
        $error("data_mux: NUM_INPUTS must be >= 2 and DATA_WIDTH >= 1");
    end

    logic [DATA_WIDTH-1:0] sel_word;
    logic                  sel_err;
    logic [DATA_WIDTH:0]   sel_d;
    logic [DATA_WIDTH:0]   sel_q;

    // Unmatched selects fall through to zero with the error flag still set.
    always_comb begin
        sel_word = '0;
        sel_err  = 1'b1;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (bus.i_select == SEL_WIDTH'(k)) begin
                sel_word = bus.i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

    assign sel_d = {sel_err, sel_word};

    mux_out_reg #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_out_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (sel_d),
        .o_q   (sel_q)
    );

    assign bus.o_output    = sel_word;
    assign bus.o_sel_err   = sel_err;
    assign bus.o_output_q  = sel_q[DATA_WIDTH-1:0];
    assign bus.o_sel_err_q = sel_q[DATA_WIDTH];

endmodule : data_mux
`default_nettype wire

// File: tb/tb_data_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mux
//  Description : Self-checking bench for data_mux (6x8 and 4x16 configurations).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mux;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    data_mux_if #(.NUM_INPUTS(6), .DATA_WIDTH(8))  bus_a ();
    data_mux_if #(.NUM_INPUTS(4), .DATA_WIDTH(16)) bus_b ();

    data_mux #(.NUM_INPUTS(6), .DATA_WIDTH(8)) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a.slave)
    );

    data_mux #(.NUM_INPUTS(4), .DATA_WIDTH(16)) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: word sel of an n-word bus of w-bit words, or zero when out of range.
    function automatic logic [31:0] ref_word(input int n, input int w,
                                             input logic [127:0] data, input int sel);
        logic [127:0] mask;
        if (sel >= n) return 32'd0;
        mask = (128'd1 << w) - 128'd1;
        return 32'((data >> (sel * w)) & mask);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [47:0]  pat;
        logic [31:0]  exp_w;
        logic         exp_e;
        logic [127:0] rbus;
        int           rsel;

        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bus_a.i_data_bus = '0;
        bus_a.i_select   = '0;
        bus_b.i_data_bus = '0;
        bus_b.i_select   = '0;
        pat = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

        // Reset state, observed before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("reset_out_q",   bus_a.o_output_q,  32'h0);
        check("reset_err_q",   bus_a.o_sel_err_q, 32'h0);
        check("reset_b_out_q", bus_b.o_output_q,  32'h0);

        @(negedge clk);
        rst = 1'b0;
        bus_a.i_data_bus = pat;

        // Every in-range select, then both out-of-range codes.
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            bus_a.i_select = 3'(s);
            #1;
            check($sformatf("comb_out_sel%0d", s), bus_a.o_output, ref_word(6, 8, 128'(pat), s));
            check($sformatf("comb_err_sel%0d", s), bus_a.o_sel_err, 32'(s >= 6));
        end

        // One-cycle latency on the registered path.
        @(negedge clk);
        bus_a.i_select = 3'd2;
        #1;
        check("lat_comb_dd", bus_a.o_output, 32'hDD);
        @(posedge clk);
        #1;
        check("lat_q_dd",   bus_a.o_output_q,  32'hDD);
        check("lat_err_q0", bus_a.o_sel_err_q, 32'h0);
        #1 bus_a.i_select = 3'd4;
        #1;
        check("comb_imm_bb", bus_a.o_output,   32'hBB);
        check("q_hold_dd",   bus_a.o_output_q, 32'hDD);
        bus_a.i_select = 3'd2;
        #1;

        // Asynchronous reset between edges.
        rst = 1'b1;
        #1;
        check("async_rst_q",    bus_a.o_output_q,  32'h0);
        check("async_rst_errq", bus_a.o_sel_err_q, 32'h0);
        check("rst_comb_dd",    bus_a.o_output,    32'hDD);
        @(posedge clk);
        #1;
        check("rst_hold_q", bus_a.o_output_q, 32'h0);

        // Release reset and capture an out-of-range select.
        @(negedge clk);
        rst = 1'b0;
        bus_a.i_select = 3'd7;
        @(posedge clk);
        #1;
        check("post_rst_q",    bus_a.o_output_q,  32'h0);
        check("post_rst_errq", bus_a.o_sel_err_q, 32'h1);

        // Random bus/select against the reference model, default configuration.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rbus = {$urandom, $urandom, $urandom, $urandom};
            rsel = int'($urandom_range(0, 7));
            bus_a.i_data_bus = rbus[47:0];
            bus_a.i_select   = 3'(rsel);
            exp_w = ref_word(6, 8, {80'd0, rbus[47:0]}, rsel);
            exp_e = (rsel >= 6);
            #1;
            check("rand_a_out", bus_a.o_output,  exp_w);
            check("rand_a_err", bus_a.o_sel_err, 32'(exp_e));
            @(posedge clk);
            #1;
            check("rand_a_out_q", bus_a.o_output_q,  exp_w);
            check("rand_a_err_q", bus_a.o_sel_err_q, 32'(exp_e));
        end

        // 4x16 configuration: exhaustive select, random data.
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                rbus = {$urandom, $urandom, $urandom, $urandom};
                bus_b.i_data_bus = rbus[63:0];
                bus_b.i_select   = 2'(s);
                exp_w = ref_word(4, 16, {64'd0, rbus[63:0]}, s);
                #1;
                check($sformatf("b_out_sel%0d", s), bus_b.o_output,  exp_w);
                check($sformatf("b_err_sel%0d", s), bus_b.o_sel_err, 32'h0);
                @(posedge clk);
                #1;
                check($sformatf("b_out_q_sel%0d", s), bus_b.o_output_q,  exp_w);
                check($sformatf("b_err_q_sel%0d", s), bus_b.o_sel_err_q, 32'h0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_data_mux
`default_nettype wire
